// File: rtl/axi_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_slave
//  Description : AXI4 responder backed by a 64-bit-wide RAM. Independent read
//                and write engines serve one INCR burst each concurrently.
//                Out-of-range beats answer DECERR; a misplaced wlast answers
//                SLVERR. All AXI outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_mem_slave #(
    parameter int          DEPTH = 1024,
    parameter logic [63:0] BASE  = 64'hc000_0000,
    parameter int          RLAT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axi_awid,
    input  logic [63:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [7:0]  s_axi_bid,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [7:0]  s_axi_arid,
    input  logic [63:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [7:0]  s_axi_rid,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] SPAN    = 64'(DEPTH) << 3;
    // Value of the wait counter on the last R_WAIT cycle (unused when RLAT=0)
    localparam logic [7:0]  RLAT_M1 = 8'(RLAT - 1);

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLV  = 2'b10;
    localparam logic [1:0] RESP_DEC  = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    function automatic logic addr_in_range(input logic [63:0] addr);
        return (addr >= BASE) && ((addr - BASE) < SPAN);
    endfunction

    function automatic logic [IW-1:0] addr_word(input logic [63:0] addr);
        logic [63:0] off;
        off = (addr - BASE) >> 3;
        return IW'(off);
    endfunction

    logic [63:0] mem [DEPTH];

    // ------------------------------------------------------------------ write
    logic [1:0]  wr_state_q, wr_state_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [7:0]  bid_q, bid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [63:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_len_q, wr_len_d;
    logic [2:0]  wr_size_q, wr_size_d;
    logic [7:0]  wr_cnt_q, wr_cnt_d;
    logic [1:0]  wr_err_q, wr_err_d;

    logic          w_wbeat;
    logic          w_wr_in;
    logic          w_wr_last;
    logic          w_wr_end;
    logic [IW-1:0] w_wr_word;
    logic [1:0]    w_wr_err;

    // Current W beat: address decode, burst termination and accumulated error
    always_comb begin
        w_wbeat   = (wr_state_q == W_DATA) && wready_q && s_axi_wvalid;
        w_wr_in   = addr_in_range(wr_addr_q);
        w_wr_word = addr_word(wr_addr_q);
        w_wr_last = (wr_cnt_q == wr_len_q);
        w_wr_end  = w_wbeat && (w_wr_last || s_axi_wlast);
        w_wr_err  = wr_err_q;
        if (!w_wr_in) begin
            w_wr_err = RESP_DEC;
        end else if ((s_axi_wlast != w_wr_last) && (wr_err_q != RESP_DEC)) begin
            w_wr_err = RESP_SLV;
        end
    end

    // Write FSM state register and write-side registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= 8'd0;
            bresp_q    <= RESP_OKAY;
            wr_addr_q  <= 64'd0;
            wr_len_q   <= 8'd0;
            wr_size_q  <= 3'd0;
            wr_cnt_q   <= 8'd0;
            wr_err_q   <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
            wr_addr_q  <= wr_addr_d;
            wr_len_q   <= wr_len_d;
            wr_size_q  <= wr_size_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // Write FSM next state
    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            W_IDLE:  if (s_axi_awvalid && awready_q) wr_state_d = W_DATA;
            W_DATA:  if (w_wr_end) wr_state_d = W_RESP;
            W_RESP:  if (bvalid_q && s_axi_bready) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Write FSM outputs and burst bookkeeping
    always_comb begin
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        wr_addr_d = wr_addr_q;
        wr_len_d  = wr_len_q;
        wr_size_d = wr_size_q;
        wr_cnt_d  = wr_cnt_q;
        wr_err_d  = wr_err_q;
        case (wr_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (s_axi_awvalid && awready_q) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    bid_d     = s_axi_awid;
                    wr_addr_d = s_axi_awaddr;
                    wr_len_d  = s_axi_awlen;
                    wr_size_d = s_axi_awsize;
                    wr_cnt_d  = 8'd0;
                    wr_err_d  = RESP_OKAY;
                end
            end
            W_DATA: begin
                if (w_wbeat) begin
                    wr_err_d  = w_wr_err;
                    wr_cnt_d  = wr_cnt_q + 8'd1;
                    wr_addr_d = wr_addr_q + (64'd1 << wr_size_q);
                    if (w_wr_end) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = w_wr_err;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                end
            end
            default: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
            end
        endcase
    end

    // RAM byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && w_wbeat && w_wr_in) begin
            for (int b = 0; b < 8; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_wr_word][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------- read
    logic [1:0]  rd_state_q, rd_state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [7:0]  rid_q, rid_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;
    logic [63:0] rd_addr_q, rd_addr_d;
    logic [7:0]  rd_len_q, rd_len_d;
    logic [2:0]  rd_size_q, rd_size_d;
    logic [7:0]  rd_cnt_q, rd_cnt_d;
    logic [7:0]  rd_wait_q, rd_wait_d;

    logic          w_ar_hs;
    logic          w_rd_hs;
    logic          w_ld;
    logic [63:0]   w_ld_addr;
    logic [7:0]    w_ld_len;
    logic [2:0]    w_ld_size;
    logic [7:0]    w_ld_cnt;
    logic          w_ld_in;
    logic [IW-1:0] w_ld_word;
    logic [63:0]   w_ld_data;

    // Beat loader: with no wait cycles the first beat is taken straight from
    // the AR channel; otherwise from the latched burst state. Memory is read
    // before this edge's write lands, so a colliding W beat is not seen.
    always_comb begin
        w_ar_hs = (rd_state_q == R_IDLE) && arready_q && s_axi_arvalid;
        w_rd_hs = (rd_state_q == R_DATA) && rvalid_q && s_axi_rready;
        w_ld    = (w_ar_hs && (RLAT == 0))
               || ((rd_state_q == R_WAIT) && (rd_wait_q == RLAT_M1))
               || (w_rd_hs && !rlast_q);
        if (rd_state_q == R_IDLE) begin
            w_ld_addr = s_axi_araddr;
            w_ld_len  = s_axi_arlen;
            w_ld_size = s_axi_arsize;
            w_ld_cnt  = 8'd0;
        end else begin
            w_ld_addr = rd_addr_q;
            w_ld_len  = rd_len_q;
            w_ld_size = rd_size_q;
            w_ld_cnt  = rd_cnt_q;
        end
        w_ld_in   = addr_in_range(w_ld_addr);
        w_ld_word = addr_word(w_ld_addr);
        w_ld_data = w_ld_in ? mem[w_ld_word] : 64'd0;
    end

    // Read FSM state register and read-side registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rid_q      <= 8'd0;
            rdata_q    <= 64'd0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
            rd_addr_q  <= 64'd0;
            rd_len_q   <= 8'd0;
            rd_size_q  <= 3'd0;
            rd_cnt_q   <= 8'd0;
            rd_wait_q  <= 8'd0;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
            rd_addr_q  <= rd_addr_d;
            rd_len_q   <= rd_len_d;
            rd_size_q  <= rd_size_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_wait_q  <= rd_wait_d;
        end
    end

    // Read FSM next state
    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (w_ar_hs) rd_state_d = (RLAT == 0) ? R_DATA : R_WAIT;
            R_WAIT:  if (rd_wait_q == RLAT_M1) rd_state_d = R_DATA;
            R_DATA:  if (w_rd_hs && rlast_q) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Read FSM outputs: accept, wait count, beat load and hold under stall
    always_comb begin
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rd_addr_d = rd_addr_q;
        rd_len_d  = rd_len_q;
        rd_size_d = rd_size_q;
        rd_cnt_d  = rd_cnt_q;
        rd_wait_d = rd_wait_q;
        case (rd_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (w_ar_hs) begin
                    arready_d = 1'b0;
                    rid_d     = s_axi_arid;
                    rd_addr_d = s_axi_araddr;
                    rd_len_d  = s_axi_arlen;
                    rd_size_d = s_axi_arsize;
                    rd_cnt_d  = 8'd0;
                    rd_wait_d = 8'd0;
                end
            end
            R_WAIT: rd_wait_d = rd_wait_q + 8'd1;
            R_DATA: begin
                if (w_rd_hs && rlast_q) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: begin
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
            end
        endcase
        if (w_ld) begin
            rvalid_d  = 1'b1;
            rdata_d   = w_ld_data;
            rresp_d   = w_ld_in ? RESP_OKAY : RESP_DEC;
            rlast_d   = (w_ld_cnt == w_ld_len);
            rd_addr_d = w_ld_addr + (64'd1 << w_ld_size);
            rd_cnt_d  = w_ld_cnt + 8'd1;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;

endmodule
`default_nettype wire
